alu_mul_seq: RTL and testbench

- Multi-cycle shift-add multiply sequencer that drives the shared 32-bit ALU through its select/operand interface, using only the ADD encoding.
- Produces the low XLEN bits of a*b (RV32 MUL). The result is identical for signed and unsigned operands.
- Sits beside the ALU in the execute stage. The core stalls on req_ready/rsp_valid while a multiply runs.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_seq.sv | 98 +++++++++
 tb/tb_alu_mul_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU select encodings and multiply sequencer state type.
// Used by the execute-stage ALU and its attached sequencers.
package alu_pkg;

    localparam logic [3:0] SEL_ADD   = 4'b0000;
    localparam logic [3:0] SEL_SUB   = 4'b1000;
    localparam logic [3:0] SEL_SLL   = 4'b0001;
    localparam logic [3:0] SEL_SRL   = 4'b0101;
    localparam logic [3:0] SEL_SRA   = 4'b1101;
    localparam logic [3:0] SEL_LT    = 4'b0010;
    localparam logic [3:0] SEL_LTU   = 4'b0011;
    localparam logic [3:0] SEL_EQL   = 4'b1010;
    localparam logic [3:0] SEL_EQU   = 4'b1011;
    localparam logic [3:0] SEL_XOR   = 4'b0100;
    localparam logic [3:0] SEL_OR    = 4'b0110;
    localparam logic [3:0] SEL_AND   = 4'b0111;
    localparam logic [3:0] SEL_PASSA = 4'b1110;
    localparam logic [3:0] SEL_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add RV32 MUL sequencer driving the shared ALU adder.
// Define ALU_MUL_SEQ_EARLY_TERM_EN to stop once no multiplier bits remain.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_select,
    input  logic [XLEN-1:0] alu_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    mul_state_t      state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        mcand  <= req_a;
                        mplier <= req_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
                    if (mplier == '0) begin
                        state <= DONE;
                    end else begin
                        if (mplier[0])
                            acc <= alu_out;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST || (mplier >> 1) == '0)
                            state <= DONE;
                    end
`else
                    if (mplier[0])
                        acc <= alu_out;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= DONE;
`endif
                end
                DONE: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        rsp_valid  = (state == DONE);
        rsp_data   = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_select = SEL_ADD;
        if (state == DONE)
            rsp_data = acc;
        // The ALU adder is only borrowed while iterating.
        if (state == RUN) begin
            alu_a = acc;
            alu_b = mcand;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq.
// Reference: truncated a*b and latency from the multiplier's bit pattern.
module tb_alu_mul_seq;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [XLEN-1:0] req_a = '0;
    logic [XLEN-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [XLEN-1:0] rsp_data;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_select;
    logic [XLEN-1:0] alu_out;

    int errs = 0;
    int checks = 0;
    logic [XLEN-1:0] got_q[$];

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_select(alu_select), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU: only addition is needed here.
    assign alu_out = (alu_select == SEL_ADD) ? alu_a + alu_b : '0;

    always @(negedge clk)
        if (rst_n && rsp_valid && rsp_ready)
            got_q.push_back(rsp_data);

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        return a * b;
    endfunction

    function automatic int exp_len(input logic [XLEN-1:0] b);
        int l;
        l = 1;
        for (int i = 0; i < XLEN; i++)
            if (b[i]) l = i + 1;
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
        return l;
`else
        return (l > 0) ? XLEN : 0;
`endif
    endfunction

    // Entered and left at a negedge.
    task automatic mul_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int stall);
        int n;
        bit busy_bad;
        bit sel_bad;
        bit hold_bad;
        int qn;
        logic [XLEN-1:0] held;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        busy_bad = 0;
        sel_bad = 0;
        do begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            n++;
            @(negedge clk);
            if (!rsp_valid && req_ready) busy_bad = 1;
            if (alu_select !== SEL_ADD) sel_bad = 1;
        end while (!rsp_valid && n < 200);
        check("latency", 64'(n), 64'(exp_len(b) + 1));
        check("busy_ready", 64'(busy_bad), 64'd0);
        check("alu_sel", 64'(sel_bad), 64'd0);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_data", 64'(rsp_data), 64'(ref_mul(a, b)));
        held = rsp_data;
        hold_bad = 0;
        repeat (stall) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || rsp_data !== held) hold_bad = 1;
        end
        check("rsp_hold", 64'(hold_bad), 64'd0);
        qn = got_q.size();
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("back_idle", {62'd0, rsp_valid, req_ready}, 64'd1);
        check("alu_idle", {alu_a, alu_b}, 64'd0);
        check("one_rsp", 64'(got_q.size()), 64'(qn + 1));
        if (got_q.size() > 0) void'(got_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XLEN-1:0] ba[3];
        logic [XLEN-1:0] bb[3];
        longint t_acc[3];
        int n;
        int q0;

        #1;
        check("rst_out", {req_ready, rsp_valid, rsp_data, alu_select},
              {1'b1, 1'b0, 32'd0, SEL_ADD});
        check("rst_alu", {alu_a, alu_b}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mul_op(32'd7, 32'd6, 0);
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        mul_op(32'h8000_0000, 32'd2, 0);
        mul_op(32'h1234_5678, 32'h9ABC_DEF0, 10);
        check("known_prod", 64'(ref_mul(32'h1234_5678, 32'h9ABC_DEF0)),
              64'h242D_2080);
        mul_op(32'd0, 32'hDEAD_BEEF, 0);
        mul_op(32'd9, 32'd0, 0);
        mul_op(32'd9, 32'h10, 2);

        // Early rsp_ready must not shortcut anything.
        rsp_ready = 1'b1;
        @(negedge clk);
        check("early_rdy", {62'd0, rsp_valid, req_ready}, 64'd1);
        rsp_ready = 1'b0;

        // Abort a run with reset.
        q0 = got_q.size();
        req_a = 32'd3;
        req_b = 32'd5;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out", {req_ready, rsp_valid, rsp_data, alu_select},
              {1'b1, 1'b0, 32'd0, SEL_ADD});
        check("abort_alu", {alu_a, alu_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_norsp", 64'(got_q.size()), 64'(q0));
        check("abort_novld", 64'(rsp_valid), 64'd0);
        mul_op(32'd3, 32'd5, 0);

        for (int i = 0; i < 10; i++) begin
            mul_op($urandom, $urandom >> $urandom_range(0, 31),
                   $urandom_range(0, 3));
        end

        // Back-to-back with req_valid and rsp_ready held high.
        ba[0] = 32'd2;        bb[0] = 32'd3;
        ba[1] = 32'hFFFF_FFFF; bb[1] = 32'hFFFF_FFFF;
        ba[2] = 32'h1_0000;   bb[2] = 32'h1_0000;
        q0 = got_q.size();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a = ba[i];
            req_b = bb[i];
            req_valid = 1'b1;
            n = 0;
            while (!req_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            t_acc[i] = $time;
            #1;
        end
        req_valid = 1'b0;
        n = 0;
        while (got_q.size() < q0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_count", 64'(got_q.size()), 64'(q0 + 3));
        for (int i = 0; i < 3; i++) begin
            if (got_q.size() > q0)
                check("b2b_data", 64'(got_q[q0]), 64'(ref_mul(ba[i], bb[i])));
            if (got_q.size() > q0) got_q.delete(q0);
        end
        for (int i = 1; i < 3; i++)
            check("b2b_gap", 64'((t_acc[i] - t_acc[i-1]) / 10),
                  64'(exp_len(bb[i-1]) + 2));
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_nodup", 64'(got_q.size()), 64'(q0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
